// File: rtl/uart_fifo_pkg.sv
// Shared constants and width helpers for the UART stream FIFO.
// Optional feature macro: UART_STREAM_FIFO_HWM_EN (see uart_stream_fifo).
package uart_fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;

    // Occupancy counter width: must hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer width: addresses 0..depth-1, at least one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// Storage array for the UART stream FIFO.
// One synchronous write port, one asynchronous read port.
module uart_fifo_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are not reset; only written on accepted pushes.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_stream_fifo.sv
// FWFT byte FIFO between the UART receiver and command parser.
// Define UART_STREAM_FIFO_HWM_EN to add the hwm high-water-mark output.
module uart_stream_fifo
    import uart_fifo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      almost_full,
    output logic                      almost_empty,
    input  logic                      err_clr,
    output logic                      overflow,
    output logic                      underflow
`ifdef UART_STREAM_FIFO_HWM_EN
    ,
    output logic [cnt_w(DEPTH)-1:0]   hwm
`endif
);

    localparam int CNT_W = cnt_w(DEPTH);
    localparam int PTR_W = ptr_w(DEPTH);

    localparam logic [CNT_W-1:0] FULL_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C   = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_C   = CNT_W'(AE_LEVEL);
    localparam logic [PTR_W-1:0] LAST_P = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_nxt;
    logic [DATA_W-1:0] rd_data;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;

    assign full         = (count == FULL_C);
    assign empty        = (count == '0);
    assign in_ready     = ~full;
    assign out_valid    = ~empty;
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);
    assign push         = in_valid & in_ready;
    assign pop          = out_valid & out_ready;
    assign out_data     = empty ? '0 : rd_data;

    uart_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (PTR_W)
    ) u_ram (
        .clk    (clk),
        .we     (push & ~flush),
        .waddr  (wr_ptr),
        .wdata  (in_data),
        .raddr  (rd_ptr),
        .rdata  (rd_data)
    );

    // Next occupancy; flush wins over any transfer this cycle.
    always_comb begin
        count_nxt = count;
        if (flush)
            count_nxt = '0;
        else if (push && !pop)
            count_nxt = count + 1'b1;
        else if (pop && !push)
            count_nxt = count - 1'b1;
    end

    // Pointers and occupancy, wrapping at DEPTH-1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_nxt;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push)
                    wr_ptr <= (wr_ptr == LAST_P) ? '0 : wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= (rd_ptr == LAST_P) ? '0 : rd_ptr + 1'b1;
            end
        end
    end

    // Sticky errors; a new error beats err_clr in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (in_valid && !in_ready)
                overflow <= 1'b1;
            else if (err_clr)
                overflow <= 1'b0;
            if (out_ready && !out_valid)
                underflow <= 1'b1;
            else if (err_clr)
                underflow <= 1'b0;
        end
    end

`ifdef UART_STREAM_FIFO_HWM_EN
    // High-water mark; err_clr restarts tracking from the new count.
    always_ff @(posedge clk) begin
        if (!rst_n)
            hwm <= '0;
        else if (err_clr)
            hwm <= count_nxt;
        else if (count_nxt > hwm)
            hwm <= count_nxt;
    end
`endif

endmodule
